// File: rtl/fft_pkg.sv
// Shared constants and types for the post-FFT datapath (transform size,
// bin packing, and the peak detector's scan states).
package fft_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int bit_width = 16;
  localparam int N         = 512;
  localparam int M         = log2(N);

  // One FFT bin exactly as it sits on the read port: real in the upper half.
  typedef struct packed {
    logic signed [bit_width-1:0] re;
    logic signed [bit_width-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    REPORT
  } pd_state_t;

endpackage

// File: rtl/fft_peak_detect_if.sv
// Signals between the peak detector (master: issues reads, reports the peak)
// and its environment (FFT core read port and downstream consumer).
interface fft_peak_detect_if;
  import fft_pkg::*;

  logic                   fft_done;
  logic [M-1:0]           rd_adr;
  complex_t               rd_data;
  logic                   busy;
  logic                   peak_valid;
  logic [M-2:0]           peak_bin;
  logic [2*bit_width-1:0] peak_mag;

  modport master (
    input  fft_done, rd_data,
    output rd_adr, busy, peak_valid, peak_bin, peak_mag
  );

  modport slave (
    output fft_done, rd_data,
    input  rd_adr, busy, peak_valid, peak_bin, peak_mag
  );

endinterface

// File: rtl/fft_mag_sq.sv
// One registered stage producing re^2 and im^2 of a bin; the bin tag and
// its valid flag travel alongside so downstream knows which bin it is.
module fft_mag_sq #(
  parameter int width = 16,
  parameter int tag_w = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [tag_w-1:0]          in_tag,
  input  logic signed [width-1:0]   re,
  input  logic signed [width-1:0]   im,
  output logic                      out_valid,
  output logic [tag_w-1:0]          out_tag,
  output logic signed [2*width-1:0] re_sq,
  output logic signed [2*width-1:0] im_sq
);

  // NOTE: only the valid flag needs reset; data registers are qualified by it,
  // so leaving them unreset keeps the reset net off the wide datapath.
  always_ff @(posedge clk) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= in_valid;
  end

  // Sign-extend before multiplying so the full 2*width product is kept.
  always_ff @(posedge clk) begin
    out_tag <= in_tag;
    re_sq   <= (2*width)'(re) * (2*width)'(re);
    im_sq   <= (2*width)'(im) * (2*width)'(im);
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Scans bins 1..N/2-1 of a finished FFT, tracks the largest re^2+im^2 and
// reports the winning bin once per scan.
module fft_peak_detect
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fft_peak_detect_if.master pd
);

  localparam int           bin_w    = M - 1;
  localparam int           mag_w    = 2 * bit_width;
  localparam logic [M-1:0] last_adr = M'(N/2 - 1);

  pd_state_t          state, state_next;
  logic [M-1:0]       adr_next;
  logic               drain_cnt;
  logic               clear_max;
  logic               load_peak;

  // Stage aligned with rd_data (one cycle after the address was issued).
  logic               a_valid;
  logic [bin_w-1:0]   a_bin;

  logic               sq_valid;
  logic [bin_w-1:0]   sq_bin;
  logic signed [mag_w-1:0] sq_re, sq_im;
  logic [mag_w-1:0]   mag;

  logic [bin_w-1:0]   max_bin, max_bin_next;
  logic [mag_w-1:0]   max_mag, max_mag_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    adr_next      = pd.rd_adr;
    clear_max     = 1'b0;
    load_peak     = 1'b0;
    pd.busy       = 1'b0;
    pd.peak_valid = 1'b0;
    unique case (state)
      IDLE: begin
        adr_next = '0;
        if (pd.fft_done) begin
          state_next = SCAN;
          adr_next   = M'(1);
          clear_max  = 1'b1;
        end
      end
      SCAN: begin
        pd.busy = 1'b1;
        if (pd.rd_adr == last_adr) begin
          state_next = DRAIN;
          adr_next   = '0;
        end else begin
          adr_next = pd.rd_adr + 1'b1;
        end
      end
      DRAIN: begin
        pd.busy = 1'b1;
        // The last bin's compare resolves in the second drain cycle, so the
        // result is captured from the max-next value at that edge.
        if (drain_cnt) begin
          state_next = REPORT;
          load_peak  = 1'b1;
        end
      end
      REPORT: begin
        pd.peak_valid = 1'b1;
        adr_next      = '0;
        if (pd.fft_done) begin
          state_next = SCAN;
          adr_next   = M'(1);
          clear_max  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        adr_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pd.rd_adr   <= '0;
      drain_cnt   <= 1'b0;
      a_valid     <= 1'b0;
      max_bin     <= '0;
      max_mag     <= '0;
      pd.peak_bin <= '0;
      pd.peak_mag <= '0;
    end else begin
      pd.rd_adr <= adr_next;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      a_valid   <= (state == SCAN);
      max_bin   <= max_bin_next;
      max_mag   <= max_mag_next;
      if (load_peak) begin
        pd.peak_bin <= max_bin_next;
        pd.peak_mag <= max_mag_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    a_bin <= pd.rd_adr[bin_w-1:0];
  end

  fft_mag_sq #(
    .width (bit_width),
    .tag_w (bin_w)
  ) u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_valid),
    .in_tag    (a_bin),
    .re        (pd.rd_data.re),
    .im        (pd.rd_data.im),
    .out_valid (sq_valid),
    .out_tag   (sq_bin),
    .re_sq     (sq_re),
    .im_sq     (sq_im)
  );

  // Both squares are non-negative and sum to at most 2^(mag_w-1): no overflow.
  assign mag = $unsigned(sq_re) + $unsigned(sq_im);

  // Strict greater-than keeps the lowest bin on ties.
  always_comb begin
    max_bin_next = max_bin;
    max_mag_next = max_mag;
    if (clear_max) begin
      max_bin_next = '0;
      max_mag_next = '0;
    end else if (sq_valid && (mag > max_mag)) begin
      max_bin_next = sq_bin;
      max_mag_next = mag;
    end
  end

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Post-FFT spectral peak finder for the tuner datapath. After the FFT core signals completion, it scans the lower half-spectrum through the FFT read port. For each bin it computes the squared magnitude re²+im², tracks the maximum, and reports the winning bin index and magnitude. The pitch-estimation logic downstream consumes the result; bin 0 (DC) is excluded.

## Interface
- bit_width, 16, width of each real/imag component (signed, two's complement)
- N, 512, FFT length; power of two, ≥ 8
- M, log2(N), FFT address width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- fft_done  in  1  one-cycle pulse from the FFT core: spectrum is ready to read
- rd_adr  out  M  FFT output read address
- rd_data  in  2*bit_width  FFT bin data; [2*bit_width-1:bit_width] = real, [bit_width-1:0] = imag; valid exactly 1 cycle after rd_adr (registered RAM read)
- busy  out  1  high while a scan is in progress
- peak_valid  out  1  one-cycle pulse: peak_bin/peak_mag just updated
- peak_bin  out  M-1  index of largest-magnitude bin, range 0..N/2-1
- peak_mag  out  2*bit_width  unsigned re²+im² of that bin

## Operation
- FSM states: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - rd_adr = 0, busy = 0.
  - fft_done → SCAN; rd_adr = 1 next cycle; running max cleared to (bin 0, mag 0).
- SCAN:
  - Issues addresses 1..N/2-1, one per cycle, incrementing.
  - After issuing N/2-1 → DRAIN.
- DRAIN:
  - 2 cycles; the pipeline empties.
  - → REPORT.
- REPORT:
  - 1 cycle.
  - peak_bin/peak_mag loaded from the running max; peak_valid = 1.
  - → IDLE.
- Pipeline, for an address issued in cycle k:
  - Data arrives in k+1.
  - Squares are registered at end of k+1.
  - Sum and compare; the running max updates at end of k+2.
  - A bin index tag travels with the data through each stage.
- Arithmetic:
  - Each square is a signed×signed product of 2*bit_width bits.
  - The sum is unsigned 2*bit_width bits. The worst case (−2^(bit_width−1))² ×2 = 2^(2*bit_width−1) fits without overflow. No truncation, no rounding.
- Compare is strict greater-than: on ties the lowest bin index wins.
- All-zero spectrum → peak_bin = 0, peak_mag = 0 (the "no signal" indication).
- Bins N/2..N-1 (mirror half) are never read.
- fft_done while busy: ignored; no restart, no queuing.
- reset at any time (including mid-scan):
  - Next cycle: IDLE, running max cleared.
  - No peak_valid is emitted for the aborted scan.

## Timing
- Reset values: rd_adr = 0, busy = 0, peak_valid = 0, peak_bin = 0, peak_mag = 0.
- fft_done in cycle 0:
  - rd_adr = 1 in cycle 1, rd_adr = a in cycle a, last address N/2-1 in cycle N/2-1.
  - busy high in cycles 1..N/2+1.
  - peak_valid high in cycle N/2+2 only (258 for N = 512).
- A new fft_done is accepted in cycle N/2+2 or later. If it arrives in cycle N/2+2, SCAN starts in cycle N/2+3.
- peak_bin/peak_mag change only in the REPORT cycle and hold until the next REPORT or reset.
- Throughput: one bin per cycle; no stalls.

## Structure
- The shared package fft_pkg holds:
  - constants bit_width, N, M;
  - the log2 function;
  - a packed complex typedef (re, im, signed bit_width each) matching the rd_data packing;
  - the FSM state enum typedef for this block.
- Sub-module fft_mag_sq: one registered stage computing the two squares, parameterised on bit_width, with the bin tag passed through. The sum, compare and FSM stay in fft_peak_detect.

## Test plan
- Single tone: bin 37 = (1000, 0), all others 0; pulse fft_done in cycle 0 → peak_valid in cycle 258 only; peak_bin = 37, peak_mag = 1_000_000; busy high cycles 1..257.
- Tie and DC exclusion: bin 0 = (30000, 30000), bins 10 and 20 = (300, −400), others (1, 1) → peak_bin = 10, peak_mag = 250_000; rd_adr never 0 during the scan and never ≥ 256.
- Extreme value: bin 255 = (−32768, −32768), others (32767, 0) → peak_bin = 255, peak_mag = 2_147_483_648.
- All zeros → peak_valid pulses; peak_bin = 0, peak_mag = 0.
- Reset mid-scan: reset in cycle 100 → cycle 101: busy = 0, rd_adr = 0, no peak_valid; previous peak_bin/peak_mag cleared to 0.
- Retrigger:
  - fft_done at cycle 50 during a scan → ignored; result still in cycle 258.
  - fft_done in cycle 258 → second scan; peak_valid in cycle 516.
